// File: rtl/axi_lite_mem_arbiter.sv
// ============================================================================
// Module      : axi_lite_mem_arbiter
// Description : Two-master (inst fetch, data load/store) to one-slave
//               AXI4-Lite arbiter. Optional feature macro: ARB_ROUND_ROBIN_EN
//               (round-robin between masters; fixed data-first otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     inst_axi_araddr,
    input  logic                  inst_axi_arvalid,
    output logic                  inst_axi_arready,
    output logic [DATA_W-1:0]     inst_axi_rdata,
    output logic [1:0]            inst_axi_rresp,
    output logic                  inst_axi_rvalid,
    input  logic                  inst_axi_rready,

    input  logic [ADDR_W-1:0]     data_axi_araddr,
    input  logic                  data_axi_arvalid,
    output logic                  data_axi_arready,
    output logic [DATA_W-1:0]     data_axi_rdata,
    output logic [1:0]            data_axi_rresp,
    output logic                  data_axi_rvalid,
    input  logic                  data_axi_rready,
    input  logic [ADDR_W-1:0]     data_axi_awaddr,
    input  logic                  data_axi_awvalid,
    output logic                  data_axi_awready,
    input  logic [DATA_W-1:0]     data_axi_wdata,
    input  logic [DATA_W/8-1:0]   data_axi_wstrb,
    input  logic                  data_axi_wvalid,
    output logic                  data_axi_wready,
    output logic [1:0]            data_axi_bresp,
    output logic                  data_axi_bvalid,
    input  logic                  data_axi_bready,

    output logic [ADDR_W-1:0]     s_axi_araddr,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [DATA_W-1:0]     s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic [ADDR_W-1:0]     s_axi_awaddr,
    output logic                  s_axi_awvalid,
    input  logic                  s_axi_awready,
    output logic [DATA_W-1:0]     s_axi_wdata,
    output logic [DATA_W/8-1:0]   s_axi_wstrb,
    output logic                  s_axi_wvalid,
    input  logic                  s_axi_wready,
    input  logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_bvalid,
    output logic                  s_axi_bready,

    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_INST = 2'b01;
    localparam logic [1:0] c_GRANT_DATA = 2'b10;

    state_t     r_state;
    logic       r_ar_done;
    logic       r_aw_done;
    logic       r_w_done;
    logic [1:0] r_grant;
`ifdef ARB_ROUND_ROBIN_EN
    // 0: inst has priority on the next contention, 1: data has priority
    logic       r_rr_ptr;
`endif

    logic   w_i_req;
    logic   w_d_wr_req;
    logic   w_d_req;
    state_t w_d_state;
    state_t w_arb_state;
    logic   w_is_i;
    logic   w_is_d;
    logic   w_is_wr;
    logic   w_ar_hs;
    logic   w_r_hs;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_b_hs;

    assign w_i_req    = inst_axi_arvalid;
    assign w_d_wr_req = data_axi_awvalid && data_axi_wvalid;
    assign w_d_req    = w_d_wr_req || data_axi_arvalid;
    assign w_d_state  = w_d_wr_req ? D_WR : D_RD;

    always_comb begin
        w_arb_state = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        if (w_d_req && (!w_i_req || r_rr_ptr)) begin
            w_arb_state = w_d_state;
        end else if (w_i_req) begin
            w_arb_state = I_RD;
        end
`else
        if (w_d_req) begin
            w_arb_state = w_d_state;
        end else if (w_i_req) begin
            w_arb_state = I_RD;
        end
`endif
    end

    assign w_is_i  = (r_state == I_RD);
    assign w_is_d  = (r_state == D_RD);
    assign w_is_wr = (r_state == D_WR);

    // Read address/data routing; AR is cut off once its handshake is done
    assign s_axi_araddr     = w_is_i ? inst_axi_araddr : data_axi_araddr;
    assign s_axi_arvalid    = !r_ar_done &&
                              ((w_is_i && inst_axi_arvalid) || (w_is_d && data_axi_arvalid));
    assign inst_axi_arready = w_is_i && !r_ar_done && s_axi_arready;
    assign data_axi_arready = w_is_d && !r_ar_done && s_axi_arready;

    assign inst_axi_rdata   = s_axi_rdata;
    assign inst_axi_rresp   = s_axi_rresp;
    assign inst_axi_rvalid  = w_is_i && s_axi_rvalid;
    assign data_axi_rdata   = s_axi_rdata;
    assign data_axi_rresp   = s_axi_rresp;
    assign data_axi_rvalid  = w_is_d && s_axi_rvalid;
    assign s_axi_rready     = (w_is_i && inst_axi_rready) || (w_is_d && data_axi_rready);

    // Write channels: AW and W complete independently
    assign s_axi_awaddr     = data_axi_awaddr;
    assign s_axi_awvalid    = w_is_wr && !r_aw_done && data_axi_awvalid;
    assign data_axi_awready = w_is_wr && !r_aw_done && s_axi_awready;
    assign s_axi_wdata      = data_axi_wdata;
    assign s_axi_wstrb      = data_axi_wstrb;
    assign s_axi_wvalid     = w_is_wr && !r_w_done && data_axi_wvalid;
    assign data_axi_wready  = w_is_wr && !r_w_done && s_axi_wready;
    assign data_axi_bresp   = s_axi_bresp;
    assign data_axi_bvalid  = w_is_wr && s_axi_bvalid;
    assign s_axi_bready     = w_is_wr && data_axi_bready;

    assign w_ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_r_hs  = s_axi_rvalid  && s_axi_rready;
    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_b_hs  = s_axi_bvalid  && s_axi_bready;

    assign grant_o = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_grant   <= c_GRANT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_state != IDLE) begin
                        r_state <= w_arb_state;
                        r_grant <= (w_arb_state == I_RD) ? c_GRANT_INST : c_GRANT_DATA;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= (w_arb_state == I_RD);
`endif
                    end
                end
                I_RD, D_RD: begin
                    if (w_ar_hs) begin
                        r_ar_done <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_state   <= IDLE;
                        r_grant   <= c_GRANT_NONE;
                        r_ar_done <= 1'b0;
                    end
                end
                D_WR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_b_hs) begin
                        r_state   <= IDLE;
                        r_grant   <= c_GRANT_NONE;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= c_GRANT_NONE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
